// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
//
// Decode-stage register file with write-to-read bypass and a per-register
// pending (scoreboard) bit used by the hazard unit.
//
// Parameters
//   DATA_W     width of each register
//   NUM_REGS   number of registers (power of two, >= 2)
//   NUM_RPORTS number of independent combinational read ports (1..4)
//   BYPASS     1 = a same-cycle write is forwarded to matching read ports
//   ZERO_REG   1 = register 0 reads as zero, ignores writes, never pending
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        synchronous reset, active-high, wins over every other input
//   WEN        writeback write enable
//   wsel       writeback register index
//   wdat       writeback data
//   rsel       packed read indices, port k at [k*SEL_W +: SEL_W]
//   rdat       packed read data,    port k at [k*DATA_W +: DATA_W]
//   rbusy      per-port flag: selected register still has a producer in flight
//   issue_en   mark register issue_sel pending
//   issue_sel  destination index of the issued instruction
//   flush      clear every pending bit (pipeline squash)
//   pend_cnt   registered population count of the pending bits
// ---------------------------------------------------------------------------
module register_file_sb #(
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = 32,
   parameter int NUM_RPORTS = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1,
   localparam int SEL_W     = $clog2(NUM_REGS),
   localparam int CNT_W     = $clog2(NUM_REGS) + 1
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         WEN,
   input  logic [SEL_W-1:0]             wsel,
   input  logic [DATA_W-1:0]            wdat,
   input  logic [NUM_RPORTS*SEL_W-1:0]  rsel,
   output logic [NUM_RPORTS*DATA_W-1:0] rdat,
   output logic [NUM_RPORTS-1:0]        rbusy,
   input  logic                         issue_en,
   input  logic [SEL_W-1:0]             issue_sel,
   input  logic                         flush,
   output logic [CNT_W-1:0]             pend_cnt
);

   localparam logic [SEL_W-1:0]  SEL_ZERO  = {SEL_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

   // Population count of a pending vector; sized so NUM_REGS itself fits.
   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
      logic [CNT_W-1:0] acc;
      acc = CNT_ZERO;
      for (int i = 0; i < NUM_REGS; i++) begin
         acc = acc + {{(CNT_W-1){1'b0}}, v[i]};
      end
      return acc;
   endfunction

   // State
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_d;
   logic [CNT_W-1:0]    pend_cnt_q;
   logic [CNT_W-1:0]    pend_cnt_d;

   // Per-port decode helpers
   logic [SEL_W-1:0]      rsel_s     [NUM_RPORTS];
   logic [NUM_RPORTS-1:0] zero_sel_s;
   logic [NUM_RPORTS-1:0] byp_hit_s;
   logic [NUM_RPORTS-1:0] iss_hit_s;
   logic                  write_ok_s;

   // A write to the hardwired zero register is silently dropped.
   always_comb begin
      write_ok_s = 1'b0;
      if (WEN && !((ZERO_REG != 0) && (wsel == SEL_ZERO))) begin
         write_ok_s = 1'b1;
      end else begin
         write_ok_s = 1'b0;
      end
   end

   // Unpack read selects and classify each port against the zero reg, the
   // writeback (bypass) and the issuing instruction.
   always_comb begin
      zero_sel_s = {NUM_RPORTS{1'b0}};
      byp_hit_s  = {NUM_RPORTS{1'b0}};
      iss_hit_s  = {NUM_RPORTS{1'b0}};
      for (int k = 0; k < NUM_RPORTS; k++) begin
         rsel_s[k]     = rsel[k*SEL_W +: SEL_W];
         zero_sel_s[k] = (ZERO_REG != 0) && (rsel_s[k] == SEL_ZERO);
         // Bypass only from a write that actually lands in the file.
         byp_hit_s[k]  = (BYPASS != 0) && write_ok_s && (wsel == rsel_s[k]);
         iss_hit_s[k]  = issue_en && (issue_sel == rsel_s[k]);
      end
   end

   // Combinational read data with zero-register forcing and bypass.
   always_comb begin
      rdat = {(NUM_RPORTS*DATA_W){1'b0}};
      for (int k = 0; k < NUM_RPORTS; k++) begin
         if (zero_sel_s[k]) begin
            rdat[k*DATA_W +: DATA_W] = DATA_ZERO;
         end else if (byp_hit_s[k]) begin
            rdat[k*DATA_W +: DATA_W] = wdat;
         end else begin
            rdat[k*DATA_W +: DATA_W] = regs_q[rsel_s[k]];
         end
      end
   end

   // Busy flags: a forwarded value clears busy unless a new producer for the
   // same register is issued in the same cycle.
   always_comb begin
      rbusy = {NUM_RPORTS{1'b0}};
      for (int k = 0; k < NUM_RPORTS; k++) begin
         if (zero_sel_s[k]) begin
            rbusy[k] = 1'b0;
         end else if (byp_hit_s[k] && !iss_hit_s[k]) begin
            rbusy[k] = 1'b0;
         end else begin
            rbusy[k] = pend_q[rsel_s[k]];
         end
      end
   end

   // Next-state pending bits: flush > issue (set) > writeback (clear) > hold.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (flush) begin
            pend_d[i] = 1'b0;
         end else if (issue_en && (issue_sel == SEL_W'(i))) begin
            pend_d[i] = 1'b1;
         end else if (WEN && (wsel == SEL_W'(i))) begin
            pend_d[i] = 1'b0;
         end else begin
            pend_d[i] = pend_q[i];
         end
      end
      if (ZERO_REG != 0) begin
         pend_d[0] = 1'b0;
      end else begin
         pend_d[0] = pend_d[0];
      end
   end

   // The count is taken from the next state so it matches pend after the edge.
   always_comb begin
      pend_cnt_d = popcount(pend_d);
   end

   // Register storage: clear on reset, otherwise accept the writeback.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= DATA_ZERO;
         end
      end else if (write_ok_s) begin
         regs_q[wsel] <= wdat;
      end else begin
         regs_q[wsel] <= regs_q[wsel];
      end
   end

   // Pending bits and their registered population count.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_q     <= {NUM_REGS{1'b0}};
         pend_cnt_q <= CNT_ZERO;
      end else begin
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign pend_cnt = pend_cnt_q;

endmodule
